// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: PC, imem requests, predecode, skid-buffered output
module if_fetch_unit #(
  parameter int             N        = 32,
  parameter logic [N-1:0]   RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  output logic         o_imem_req,
  output logic [N-1:0] o_imem_addr,
  input  logic         i_imem_ack,
  input  logic [31:0]  i_imem_rdata,
  output logic         o_bp_is_branch,
  output logic [N-1:0] o_bp_branch_pc,
  input  logic         i_bp_prediction,
  input  logic         i_ex_redirect,
  input  logic [N-1:0] i_ex_redirect_pc,
  input  logic         i_id_stall,
  output logic         o_if_valid,
  output logic [N-1:0] o_if_pc,
  output logic [31:0]  o_if_instr,
  output logic         o_if_pred_taken
);

  typedef enum logic {FETCH, DISCARD} state_t;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_t       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] addr_q, addr_d;
  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_pc_q, out_pc_d;
  logic [31:0]  out_instr_q, out_instr_d;
  logic         out_pred_q, out_pred_d;
  logic         skid_valid_q, skid_valid_d;
  logic [N-1:0] skid_pc_q, skid_pc_d;
  logic [31:0]  skid_instr_q, skid_instr_d;
  logic         skid_pred_q, skid_pred_d;

  logic         req;
  logic         accept;
  logic         is_b;
  logic         is_jal;
  logic         pred;
  logic [N-1:0] imm_b;
  logic [N-1:0] imm_j;
  logic [N-1:0] next_pc;

  // Predecode of the returned word; only acted on when the word is accepted.
  always_comb begin
    req    = !rst && ((state_q == FETCH && !skid_valid_q) || state_q == DISCARD);
    accept = req && state_q == FETCH && i_imem_ack && !i_ex_redirect;
    is_b   = i_imem_rdata[6:0] == OP_BRANCH;
    is_jal = i_imem_rdata[6:0] == OP_JAL;
    imm_b  = {{(N-13){i_imem_rdata[31]}}, i_imem_rdata[31], i_imem_rdata[7],
              i_imem_rdata[30:25], i_imem_rdata[11:8], 1'b0};
    imm_j  = {{(N-21){i_imem_rdata[31]}}, i_imem_rdata[31], i_imem_rdata[19:12],
              i_imem_rdata[20], i_imem_rdata[30:21], 1'b0};
    next_pc = addr_q + N'(4);
    pred    = 1'b0;
    if (is_b && i_bp_prediction) begin
      next_pc = addr_q + imm_b;
      pred    = 1'b1;
    end else if (is_jal) begin
      next_pc = addr_q + imm_j;
      pred    = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    out_valid_d  = out_valid_q;
    out_pc_d     = out_pc_q;
    out_instr_d  = out_instr_q;
    out_pred_d   = out_pred_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pred_d  = skid_pred_q;

    if (i_ex_redirect) begin
      pc_d         = i_ex_redirect_pc;
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      // A request still outstanding must be drained before the new address can go out.
      if ((req && i_imem_ack) || (state_q == FETCH && !req)) begin
        state_d = FETCH;
        addr_d  = i_ex_redirect_pc;
      end else if (state_q == FETCH) begin
        state_d = DISCARD;
      end
    end else begin
      if (state_q == DISCARD && i_imem_ack) begin
        state_d = FETCH;
        addr_d  = pc_q;
      end
      if (accept) begin
        pc_d   = next_pc;
        addr_d = next_pc;
      end
      if (!out_valid_q || !i_id_stall) begin
        if (skid_valid_q) begin
          out_valid_d  = 1'b1;
          out_pc_d     = skid_pc_q;
          out_instr_d  = skid_instr_q;
          out_pred_d   = skid_pred_q;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          out_valid_d = 1'b1;
          out_pc_d    = addr_q;
          out_instr_d = i_imem_rdata;
          out_pred_d  = pred;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (accept) begin
        skid_valid_d = 1'b1;
        skid_pc_d    = addr_q;
        skid_instr_d = i_imem_rdata;
        skid_pred_d  = pred;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      out_valid_q  <= 1'b0;
      out_pc_q     <= '0;
      out_instr_q  <= '0;
      out_pred_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      skid_pred_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_instr_q  <= out_instr_d;
      out_pred_q   <= out_pred_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pred_q  <= skid_pred_d;
    end
  end

  assign o_imem_req      = req;
  assign o_imem_addr     = addr_q;
  assign o_bp_is_branch  = accept && is_b;
  assign o_bp_branch_pc  = addr_q;
  assign o_if_valid      = out_valid_q;
  assign o_if_pc         = out_pc_q;
  assign o_if_instr      = out_instr_q;
  assign o_if_pred_taken = out_pred_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed table and sequence checks for if_fetch_unit
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BEQ = 32'h0000_0863;
  localparam logic [31:0] JAL = 32'hFF9F_F06F;

  logic        clk = 1'b0;
  logic        rst;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic        o_bp_is_branch;
  logic [31:0] o_bp_branch_pc;
  logic        i_bp_prediction;
  logic        i_ex_redirect;
  logic [31:0] i_ex_redirect_pc;
  logic        i_id_stall;
  logic        o_if_valid;
  logic [31:0] o_if_pc;
  logic [31:0] o_if_instr;
  logic        o_if_pred_taken;

  int n_checks = 0;
  int n_errors = 0;

  if_fetch_unit #(.N(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_ack(i_imem_ack), .i_imem_rdata(i_imem_rdata),
    .o_bp_is_branch(o_bp_is_branch), .o_bp_branch_pc(o_bp_branch_pc),
    .i_bp_prediction(i_bp_prediction),
    .i_ex_redirect(i_ex_redirect), .i_ex_redirect_pc(i_ex_redirect_pc),
    .i_id_stall(i_id_stall),
    .o_if_valid(o_if_valid), .o_if_pc(o_if_pc),
    .o_if_instr(o_if_instr), .o_if_pred_taken(o_if_pred_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        pred;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_isb;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_pred;
  } vec_t;

  vec_t tbl [14];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    i_imem_ack = 1'b0;
    i_imem_rdata = NOP;
    i_bp_prediction = 1'b0;
    i_ex_redirect = 1'b0;
    i_ex_redirect_pc = 32'h0;
    i_id_stall = 1'b0;
    @(negedge clk);
  endtask

  // One cycle against a memory that tags each word with its address (opcode stays OP-IMM).
  task automatic cyc(input logic r, input logic stall, input logic ack, input logic redir,
                     input logic [31:0] rpc, input logic e_req, input logic [31:0] e_addr,
                     input logic e_valid, input logic [31:0] e_pc, input string tag);
    @(negedge clk);
    rst = r;
    i_id_stall = stall;
    i_imem_ack = ack;
    i_ex_redirect = redir;
    i_ex_redirect_pc = rpc;
    i_bp_prediction = 1'b0;
    i_imem_rdata = {o_imem_addr[19:0], 12'h013};
    #1;
    chk1({tag, ".req"}, o_imem_req, e_req);
    chk32({tag, ".addr"}, o_imem_addr, e_addr);
    chk1({tag, ".valid"}, o_if_valid, e_valid);
    chk1({tag, ".is_branch"}, o_bp_is_branch, 1'b0);
    if (e_valid) begin
      chk32({tag, ".pc"}, o_if_pc, e_pc);
      chk32({tag, ".instr"}, o_if_instr, {e_pc[19:0], 12'h013});
    end
  endtask

  initial begin
    //            rst   ack   rdata pred  redir rpc        e_req e_addr     e_isb valid e_pc       e_instr e_pred
    tbl[0]  = '{1'b1, 1'b1, NOP, 1'b0, 1'b0, 32'h0,  1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, NOP, 1'b0, 1'b0, 32'h0,  1'b1, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, NOP, 1'b0, 1'b0, 32'h0,  1'b1, 32'h04, 1'b0, 1'b1, 32'h00, NOP,   1'b0};
    tbl[3]  = '{1'b0, 1'b1, NOP, 1'b0, 1'b0, 32'h0,  1'b1, 32'h08, 1'b0, 1'b1, 32'h04, NOP,   1'b0};
    tbl[4]  = '{1'b0, 1'b1, NOP, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0C, 1'b0, 1'b1, 32'h08, NOP,   1'b0};
    tbl[5]  = '{1'b0, 1'b1, BEQ, 1'b1, 1'b0, 32'h0,  1'b1, 32'h10, 1'b1, 1'b1, 32'h0C, NOP,   1'b0};
    tbl[6]  = '{1'b0, 1'b1, NOP, 1'b0, 1'b1, 32'h10, 1'b1, 32'h20, 1'b0, 1'b1, 32'h10, BEQ,   1'b1};
    tbl[7]  = '{1'b0, 1'b1, BEQ, 1'b0, 1'b0, 32'h0,  1'b1, 32'h10, 1'b1, 1'b0, 32'h00, 32'h0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, NOP, 1'b0, 1'b0, 32'h0,  1'b1, 32'h14, 1'b0, 1'b1, 32'h10, BEQ,   1'b0};
    tbl[9]  = '{1'b0, 1'b1, NOP, 1'b0, 1'b1, 32'h08, 1'b1, 32'h18, 1'b0, 1'b1, 32'h14, NOP,   1'b0};
    tbl[10] = '{1'b0, 1'b1, JAL, 1'b1, 1'b0, 32'h0,  1'b1, 32'h08, 1'b0, 1'b0, 32'h00, 32'h0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, NOP, 1'b0, 1'b0, 32'h0,  1'b1, 32'h00, 1'b0, 1'b1, 32'h08, JAL,   1'b1};
    tbl[12] = '{1'b0, 1'b0, NOP, 1'b0, 1'b0, 32'h0,  1'b1, 32'h04, 1'b0, 1'b1, 32'h00, NOP,   1'b0};
    tbl[13] = '{1'b0, 1'b0, NOP, 1'b0, 1'b0, 32'h0,  1'b1, 32'h04, 1'b0, 1'b0, 32'h00, 32'h0, 1'b0};

    reset_dut();
    chk1("reset.valid", o_if_valid, 1'b0);
    chk32("reset.pc", o_if_pc, 32'h0);
    chk32("reset.instr", o_if_instr, 32'h0);
    chk1("reset.pred", o_if_pred_taken, 1'b0);
    chk1("reset.req", o_imem_req, 1'b0);

    // Streaming, branch taken / not taken, JAL, redirects coinciding with acks.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rst = tbl[i].rst;
      i_imem_ack = tbl[i].ack;
      i_imem_rdata = tbl[i].rdata;
      i_bp_prediction = tbl[i].pred;
      i_ex_redirect = tbl[i].redir;
      i_ex_redirect_pc = tbl[i].rpc;
      i_id_stall = 1'b0;
      #1;
      chk1($sformatf("t%0d.req", i), o_imem_req, tbl[i].e_req);
      chk32($sformatf("t%0d.addr", i), o_imem_addr, tbl[i].e_addr);
      chk1($sformatf("t%0d.is_branch", i), o_bp_is_branch, tbl[i].e_isb);
      if (tbl[i].e_isb)
        chk32($sformatf("t%0d.branch_pc", i), o_bp_branch_pc, tbl[i].e_addr);
      chk1($sformatf("t%0d.valid", i), o_if_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        chk32($sformatf("t%0d.pc", i), o_if_pc, tbl[i].e_pc);
        chk32($sformatf("t%0d.instr", i), o_if_instr, tbl[i].e_instr);
        chk1($sformatf("t%0d.pred", i), o_if_pred_taken, tbl[i].e_pred);
      end
    end

    // Stall for three cycles while streaming: one word into the skid, then drained in order.
    reset_dut();
    cyc(0, 0, 1, 0, 0, 1, 32'h00, 0, 32'h00, "st1");
    cyc(0, 0, 1, 0, 0, 1, 32'h04, 1, 32'h00, "st2");
    cyc(0, 1, 1, 0, 0, 1, 32'h08, 1, 32'h04, "st3");
    cyc(0, 1, 1, 0, 0, 0, 32'h0C, 1, 32'h04, "st4");
    cyc(0, 1, 1, 0, 0, 0, 32'h0C, 1, 32'h04, "st5");
    cyc(0, 0, 1, 0, 0, 0, 32'h0C, 1, 32'h04, "st6");
    cyc(0, 0, 1, 0, 0, 1, 32'h0C, 1, 32'h08, "st7");
    cyc(0, 0, 1, 0, 0, 1, 32'h10, 1, 32'h0C, "st8");
    cyc(0, 0, 1, 0, 0, 1, 32'h14, 1, 32'h10, "st9");

    // Redirect while a request is pending: the late word is dropped, then fetch resumes at 0x100.
    reset_dut();
    cyc(0, 0, 0, 1, 32'h100, 1, 32'h000, 0, 32'h000, "dl1");
    cyc(0, 0, 0, 0, 32'h0,   1, 32'h000, 0, 32'h000, "dl2");
    cyc(0, 0, 1, 0, 32'h0,   1, 32'h000, 0, 32'h000, "dl3");
    cyc(0, 0, 0, 0, 32'h0,   1, 32'h100, 0, 32'h000, "dl4");
    cyc(0, 0, 1, 0, 32'h0,   1, 32'h100, 0, 32'h000, "dl5");
    cyc(0, 0, 0, 0, 32'h0,   1, 32'h104, 1, 32'h100, "dl6");

    // Reset pulsed in the middle of a stream.
    reset_dut();
    cyc(0, 0, 1, 0, 0, 1, 32'h00, 0, 32'h00, "rs1");
    cyc(0, 0, 1, 0, 0, 1, 32'h04, 1, 32'h00, "rs2");
    cyc(0, 0, 1, 0, 0, 1, 32'h08, 1, 32'h04, "rs3");
    cyc(1, 0, 1, 0, 0, 0, 32'h0C, 1, 32'h08, "rs4");
    cyc(0, 0, 1, 0, 0, 1, 32'h00, 0, 32'h00, "rs5");
    chk32("rs5.pc_cleared", o_if_pc, 32'h0);
    chk32("rs5.instr_cleared", o_if_instr, 32'h0);
    chk1("rs5.pred_cleared", o_if_pred_taken, 1'b0);
    cyc(0, 0, 1, 0, 0, 1, 32'h04, 1, 32'h00, "rs6");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
